// File: rtl/regfile_sb_if.sv
// Register-file bus between the ID stage (master) and regfile_sb (slave).
// Carries the two source read ports, the ID destination used for WAW checks, the EX/MEM/WB
// forwarding and commit ports, the link port and the long-latency scoreboard controls.
// master: pipeline side, drives addresses and write ports, receives read data and stalls.
// slave : register file side.
interface regfile_sb_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic [AW-1:0]   r1_addr;
  logic            r1_used;
  logic [AW-1:0]   r2_addr;
  logic            r2_used;
  logic [AW-1:0]   rd_addr;
  logic            rd_used;
  logic [XLEN-1:0] r1_data;
  logic [XLEN-1:0] r2_data;

  logic            ex_we;
  logic [AW-1:0]   ex_wa;
  logic [XLEN-1:0] ex_wd;
  logic            ex_is_load;
  logic            me_we;
  logic [AW-1:0]   me_wa;
  logic [XLEN-1:0] me_wd;
  logic            wb_we;
  logic [AW-1:0]   wb_wa;
  logic [XLEN-1:0] wb_wd;

  logic            link_we;
  logic [XLEN-1:0] link_wd;

  logic            mc_issue;
  logic [AW-1:0]   mc_wa;
  logic            mc_done;
  logic [AW-1:0]   mc_done_wa;

  logic            pause;
  logic            sb_busy;

  modport master (
    output r1_addr, r1_used, r2_addr, r2_used, rd_addr, rd_used,
    output ex_we, ex_wa, ex_wd, ex_is_load, me_we, me_wa, me_wd, wb_we, wb_wa, wb_wd,
    output link_we, link_wd, mc_issue, mc_wa, mc_done, mc_done_wa,
    input  r1_data, r2_data, pause, sb_busy
  );

  modport slave (
    input  r1_addr, r1_used, r2_addr, r2_used, rd_addr, rd_used,
    input  ex_we, ex_wa, ex_wd, ex_is_load, me_we, me_wa, me_wd, wb_we, wb_wa, wb_wd,
    input  link_we, link_wd, mc_issue, mc_wa, mc_done, mc_done_wa,
    output r1_data, r2_data, pause, sb_busy
  );
endinterface

// File: rtl/regfile_sb.sv
// 2-read/1-write integer register file for the ID stage of a 5-stage pipeline.
// - Reads forward EX > ME > WB > array; x0 always reads 0.
// - pause stalls on load-use hazards and on sources/destination pending in the
//   long-latency scoreboard (mul/div).
// - A dedicated link port writes LINK_REG and wins over a same-cycle WB to it.
// Optional feature, macro RF_TICK_CNT_EN: a CNT_DIV-bit prescaler increments CNT_REG on
// every prescaler wrap; WB/link writes to CNT_REG in that cycle win over the tick.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous reset, active low
//   bus    : regfile_sb_if slave modport (read ports, forwarding, commit, scoreboard)
module regfile_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned LINK_REG = 31,
  parameter int unsigned CNT_REG  = 30,
  parameter int unsigned CNT_DIV  = 20
) (
  input logic         clk_i,
  input logic         rst_ni,
  regfile_sb_if.slave bus
);
  localparam int unsigned NREG = 2 ** AW;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] pending_q, pending_d;
  logic            tick_wrap;

  // ---------------------------------------------------------------------------
  // Read ports with forwarding
  // ---------------------------------------------------------------------------
  logic [AW-1:0]   src_addr [2];
  logic [XLEN-1:0] src_data [2];

  assign src_addr[0] = bus.r1_addr;
  assign src_addr[1] = bus.r2_addr;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      src_data[i] = regs_q[src_addr[i]];
      if (src_addr[i] == '0) begin
        src_data[i] = '0;
      end else if (bus.ex_we && bus.ex_wa == src_addr[i]) begin
        // A load in EX has no data yet; it must not fall through to older stages.
        // The load-use stall covers the consumer, so the array value is a don't-care.
        if (!bus.ex_is_load) src_data[i] = bus.ex_wd;
      end else if (bus.me_we && bus.me_wa == src_addr[i]) begin
        src_data[i] = bus.me_wd;
      end else if (bus.wb_we && bus.wb_wa == src_addr[i]) begin
        src_data[i] = bus.wb_wd;
      end
    end
  end

  assign bus.r1_data = src_data[0];
  assign bus.r2_data = src_data[1];

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  logic load_use, sb_hit;

  assign load_use = bus.ex_we && bus.ex_is_load && (bus.ex_wa != '0) &&
                    ((bus.r1_used && bus.ex_wa == bus.r1_addr) ||
                     (bus.r2_used && bus.ex_wa == bus.r2_addr));

  assign sb_hit = (pending_q[bus.r1_addr] && bus.r1_used) ||
                  (pending_q[bus.r2_addr] && bus.r2_used) ||
                  (pending_q[bus.rd_addr] && bus.rd_used);

  assign bus.pause   = load_use || sb_hit;
  assign bus.sb_busy = |pending_q;

  // ---------------------------------------------------------------------------
  // Scoreboard: set wins over a same-cycle clear of the same entry
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_d = pending_q;
    if (bus.mc_done)  pending_d[bus.mc_done_wa] = 1'b0;
    if (bus.mc_issue) pending_d[bus.mc_wa]      = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pending_q <= '0;
    else         pending_q <= pending_d;
  end

  // ---------------------------------------------------------------------------
  // Optional tick prescaler
  // ---------------------------------------------------------------------------
`ifdef RF_TICK_CNT_EN
  logic [CNT_DIV-1:0] presc_q;

  assign tick_wrap = &presc_q;

  // Free-running; natural wrap to 0, unaffected by writes to CNT_REG.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) presc_q <= '0;
    else         presc_q <= presc_q + 1'b1;
  end
`else
  logic unused_cnt_cfg;

  assign tick_wrap      = 1'b0;
  assign unused_cnt_cfg = ^{CNT_REG[0], CNT_DIV[0]};
`endif

  // ---------------------------------------------------------------------------
  // Array writes; later assignments take priority: tick < WB < link
  // ---------------------------------------------------------------------------
  always_comb begin
    regs_d = regs_q;
    if (tick_wrap)                    regs_d[CNT_REG]   = regs_q[CNT_REG] + XLEN'(1);
    if (bus.wb_we && bus.wb_wa != '0) regs_d[bus.wb_wa] = bus.wb_wd;
    if (bus.link_we)                  regs_d[LINK_REG]  = bus.link_wd;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
`ifdef RF_TICK_CNT_EN
  localparam int unsigned CNT_DIV = 2;
`else
  localparam int unsigned CNT_DIV = 20;
`endif

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(XLEN), .AW(AW)) bus ();

  regfile_sb #(
    .XLEN(XLEN), .AW(AW), .LINK_REG(31), .CNT_REG(30), .CNT_DIV(CNT_DIV)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  // Scoreboard of expected observations: kind 0=r1_data 1=r2_data 2=pause 3=sb_busy
  typedef struct {
    int          kind;
    logic [31:0] val;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   step_id = 0;

  function automatic string kname(input int k);
    case (k)
      0:       return "r1_data";
      1:       return "r2_data";
      2:       return "pause";
      default: return "sb_busy";
    endcase
  endfunction

  function automatic logic [31:0] observe(input int k);
    case (k)
      0:       return bus.r1_data;
      1:       return bus.r2_data;
      2:       return {31'b0, bus.pause};
      default: return {31'b0, bus.sb_busy};
    endcase
  endfunction

  task automatic expect_val(input int k, input logic [31:0] v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.id   = step_id;
    exp_q.push_back(e);
  endtask

  // Pop every queued expectation and compare against the current outputs.
  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      obs = observe(e.kind);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL step%0d %s observed=%h expected=%h", e.id, kname(e.kind), obs, e.val);
      end
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    step_id++;
  endtask

  task automatic clear_inputs();
    bus.r1_addr = '0; bus.r1_used = 1'b0; bus.r2_addr = '0; bus.r2_used = 1'b0;
    bus.rd_addr = '0; bus.rd_used = 1'b0;
    bus.ex_we = 1'b0; bus.ex_wa = '0; bus.ex_wd = '0; bus.ex_is_load = 1'b0;
    bus.me_we = 1'b0; bus.me_wa = '0; bus.me_wd = '0;
    bus.wb_we = 1'b0; bus.wb_wa = '0; bus.wb_wd = '0;
    bus.link_we = 1'b0; bus.link_wd = '0;
    bus.mc_issue = 1'b0; bus.mc_wa = '0; bus.mc_done = 1'b0; bus.mc_done_wa = '0;
  endtask

  initial begin
    clear_inputs();
    // Reset state
    #3;
    bus.r1_addr = 5; bus.r1_used = 1'b1;
    expect_val(0, 32'h0); expect_val(2, 0); expect_val(3, 0);
    check_all();
    next_cycle();
    rst_ni = 1'b1;

    // WB x5=0x11: forwarded in the same cycle, from the array the next
    next_cycle();
    bus.wb_we = 1'b1; bus.wb_wa = 5; bus.wb_wd = 32'h11;
    expect_val(0, 32'h11);
    check_all();
    next_cycle();
    bus.wb_we = 1'b0;
    expect_val(0, 32'h11); expect_val(2, 0);
    check_all();

    // Forwarding priority on x7
    next_cycle();
    bus.r1_addr = 7; bus.r2_addr = 7; bus.r2_used = 1'b1;
    bus.ex_we = 1'b1; bus.ex_wa = 7; bus.ex_wd = 32'hA;
    bus.me_we = 1'b1; bus.me_wa = 7; bus.me_wd = 32'hB;
    bus.wb_we = 1'b1; bus.wb_wa = 7; bus.wb_wd = 32'hC;
    expect_val(0, 32'hA); expect_val(1, 32'hA); expect_val(2, 0);
    check_all();
    next_cycle();
    bus.ex_we = 1'b0;
    expect_val(0, 32'hB);
    check_all();
    next_cycle();
    bus.me_we = 1'b0;
    expect_val(1, 32'hC);
    check_all();
    next_cycle();
    bus.wb_we = 1'b0;
    expect_val(0, 32'hC);
    check_all();

    // Load-use on x3
    next_cycle();
    clear_inputs();
    bus.ex_we = 1'b1; bus.ex_is_load = 1'b1; bus.ex_wa = 3; bus.ex_wd = 32'hDEAD;
    bus.me_we = 1'b1; bus.me_wa = 3; bus.me_wd = 32'h77;
    bus.r2_addr = 3; bus.r2_used = 1'b1; bus.r1_addr = 3;
    expect_val(2, 1);
    expect_val(0, 32'h0);  // load in EX blocks the ME forward
    check_all();
    next_cycle();
    bus.r2_used = 1'b0;
    expect_val(2, 0);
    check_all();
    next_cycle();
    bus.ex_wa = 0; bus.r1_addr = 0; bus.r1_used = 1'b1; bus.me_we = 1'b0;
    expect_val(2, 0); expect_val(0, 32'h0);
    check_all();

    // Scoreboard on x9
    next_cycle();
    clear_inputs();
    bus.mc_issue = 1'b1; bus.mc_wa = 9;
    expect_val(3, 0);
    check_all();
    next_cycle();
    bus.mc_issue = 1'b0;
    bus.r1_addr = 9; bus.r1_used = 1'b1;
    expect_val(2, 1); expect_val(3, 1);
    check_all();
    next_cycle();
    bus.r1_used = 1'b0; bus.rd_addr = 9; bus.rd_used = 1'b1;  // WAW
    expect_val(2, 1);
    check_all();
    next_cycle();
    bus.rd_used = 1'b0; bus.r1_used = 1'b1;
    bus.mc_done = 1'b1; bus.mc_done_wa = 9;
    bus.wb_we = 1'b1; bus.wb_wa = 9; bus.wb_wd = 32'h55;
    expect_val(2, 1); expect_val(0, 32'h55);
    check_all();
    next_cycle();
    clear_inputs();
    bus.r1_addr = 9; bus.r1_used = 1'b1;
    expect_val(2, 0); expect_val(3, 0); expect_val(0, 32'h55);
    check_all();

    // Issue and done on the same entry: set wins
    next_cycle();
    bus.mc_issue = 1'b1; bus.mc_wa = 12; bus.mc_done = 1'b1; bus.mc_done_wa = 12;
    next_cycle();
    clear_inputs();
    bus.r2_addr = 12; bus.r2_used = 1'b1;
    expect_val(3, 1); expect_val(2, 1);
    check_all();
    next_cycle();
    bus.mc_done = 1'b1; bus.mc_done_wa = 12;
    next_cycle();
    bus.mc_done = 1'b1; bus.mc_done_wa = 13;  // clear bit: no-op
    expect_val(3, 0); expect_val(2, 0);
    check_all();
    next_cycle();
    clear_inputs();
    bus.mc_issue = 1'b1; bus.mc_wa = 0;  // x0 never pending
    next_cycle();
    clear_inputs();
    bus.r1_used = 1'b1;
    expect_val(3, 0); expect_val(2, 0);
    check_all();

    // Link vs WB collision on x31; WB to x0 ignored
    next_cycle();
    bus.link_we = 1'b1; bus.link_wd = 32'h400;
    bus.wb_we = 1'b1; bus.wb_wa = 31; bus.wb_wd = 32'h99;
    next_cycle();
    clear_inputs();
    bus.r1_addr = 31; bus.r2_addr = 0;
    bus.wb_we = 1'b1; bus.wb_wa = 0; bus.wb_wd = 32'hDEADBEEF;
    expect_val(0, 32'h400); expect_val(1, 32'h0);
    check_all();
    next_cycle();
    clear_inputs();
    expect_val(1, 32'h0);
    check_all();

    // Reset mid-operation clears pending and registers
    next_cycle();
    bus.mc_issue = 1'b1; bus.mc_wa = 4;
    next_cycle();
    clear_inputs();
    bus.r1_addr = 5; bus.r2_addr = 4; bus.r2_used = 1'b1;
    expect_val(3, 1); expect_val(0, 32'h11);
    check_all();
    rst_ni = 1'b0;
    expect_val(3, 0); expect_val(2, 0); expect_val(0, 32'h0);
    check_all();
    next_cycle();
    rst_ni = 1'b1;

    // x30 after reset: ticks once every 4 cycles when the counter is built in
    bus.r2_addr = 30; bus.r2_used = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
`ifdef RF_TICK_CNT_EN
      expect_val(1, 32'(k / 4));
`else
      expect_val(1, 32'h0);
`endif
      check_all();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
